// File: rtl/addsub_share_pkg.sv
// Shared types for the time-shared add/sub controller: FSM states, sign-control codes,
// and the round-robin pick used by the arbiter (searches last+1, last+2, ... mod n_req).
package addsub_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // sign[1] negates A, sign[0] negates B
  localparam logic [1:0] ADD_AB  = 2'b00;
  localparam logic [1:0] SUB_B   = 2'b01;
  localparam logic [1:0] SUB_A   = 2'b10;
  localparam logic [1:0] NEG_SUM = 2'b11;

  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         last,
                                    input int                 n_req);
    pick_t p;
    int    c;
    p = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      c = (int'(last) + k) % n_req;
      if (k <= n_req && !p.hit && valid[3'(c)]) begin
        p.hit = 1'b1;
        p.idx = 3'(c);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/signed_addsub_core.sv
// Combinational signed add/sub with overflow detect; zero latency, no flow control.
// SATURATE_EN defined: overflowed results clamp to the signed max/min instead of wrapping.
module signed_addsub_core
  import addsub_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sign,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  // WIDTH+2 bits hold every sum exactly, including -(min) - (min) = 2^WIDTH
  logic signed [WIDTH+1:0] ax;
  logic signed [WIDTH+1:0] bx;
  logic signed [WIDTH+1:0] r;

  always_comb begin
    ax = {{2{a[WIDTH-1]}}, a};
    bx = {{2{b[WIDTH-1]}}, b};
    unique case (sign)
      ADD_AB:  r = ax + bx;
      SUB_B:   r = ax - bx;
      SUB_A:   r = bx - ax;
      NEG_SUM: r = -ax - bx;
      default: r = ax + bx;
    endcase
    // fits in WIDTH signed bits iff the top three bits agree
    ovf = ~((&r[WIDTH+1:WIDTH-1]) | ~(|r[WIDTH+1:WIDTH-1]));
`ifdef SATURATE_EN
    if (ovf) begin
      result = r[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      result = r[WIDTH-1:0];
    end
`else
    result = r[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/addsub_share_ctrl.sv
// Round-robin share of one signed add/sub core; accept -> rsp_valid two edges later, 1 op / 3 cycles.
// At most one req_ready, only in IDLE; response fields hold until rsp_valid & rsp_ready.
module addsub_share_ctrl
  import addsub_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*2-1:0] req_sign,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_ovf
);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   op_id;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [1:0]        op_sign;
  logic [WIDTH-1:0]  core_result;
  logic              core_ovf;
  pick_t             pick;
  logic [ID_W-1:0]   gnt;
  logic              accept;

  always_comb begin
    pick   = rr_pick(MAX_REQ'(req_valid), 3'(last), N_REQ);
    gnt    = ID_W'(pick.idx);
    // ready is combinational, so keep it low while reset is asserted
    accept = (state == IDLE) && pick.hit && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt] = 1'b1;
    end
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= ID_W'(N_REQ - 1);
      op_id      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sign    <= '0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
    end else begin
      if (accept) begin
        op_a    <= req_a[gnt*WIDTH +: WIDTH];
        op_b    <= req_b[gnt*WIDTH +: WIDTH];
        op_sign <= req_sign[gnt*2 +: 2];
        op_id   <= gnt;
        last    <= gnt;
      end
      if (state == EXEC) begin
        rsp_result <= core_result;
        rsp_ovf    <= core_ovf;
      end
    end
  end

  assign rsp_id = op_id;

  signed_addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (op_a),
    .b      (op_b),
    .sign   (op_sign),
    .result (core_result),
    .ovf    (core_ovf)
  );

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Bench for addsub_share_ctrl: directed cases plus randomized traffic against a queue-based model.
module tb_addsub_share_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*2-1:0] req_sign;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addsub_share_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sign   (req_sign),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic straight from the sign rules, in plain integers
  function automatic void model_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [1:0] s,
                                     output logic [W-1:0] res, output logic ovf);
    int x, y, r, vmax, vmin;
    vmax = (1 << (W-1)) - 1;
    vmin = -(1 << (W-1));
    x = int'($signed(a));
    y = int'($signed(b));
    if (s[1]) x = -x;
    if (s[0]) y = -y;
    r   = x + y;
    ovf = (r > vmax) || (r < vmin);
`ifdef SATURATE_EN
    if (ovf) r = (r > 0) ? vmax : vmin;
`endif
    res = r[W-1:0];
  endfunction

  function automatic int model_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0:       return 8'h7F;
      1:       return 8'h80;
      2:       return 8'h00;
      3:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  typedef struct {
    int         id;
    logic [W-1:0] res;
    logic       ovf;
    int         edge_no;
  } exp_t;

  exp_t         exp_q[$];
  int           grant_log[$];
  int           m_last = N - 1;
  int           cyc = 0;
  int           mon_g;
  logic [N-1:0] mon_rdy;
  logic         mon_hold = 1'b0;
  logic         mon_prev_v = 1'b0;
  exp_t         mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Model-side monitor: an op is outstanding from accept until its response handshake
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_last     = N - 1;
      mon_hold   = 1'b0;
      mon_prev_v = 1'b0;
    end else begin
      mon_g   = model_pick(req_valid, m_last);
      mon_rdy = '0;
      if (exp_q.size() == 0 && mon_g >= 0) mon_rdy[mon_g] = 1'b1;
      check_eq("req_ready", 32'(req_ready), 32'(mon_rdy));
      if (mon_hold) check_eq("rsp_hold", 32'(rsp_valid), 32'd1);
      if (rsp_valid && !mon_prev_v && exp_q.size() > 0)
        check_eq("latency", cyc, exp_q[0].edge_no + 1);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          check_eq("rsp_id", 32'(rsp_id), exp_q[0].id);
          check_eq("rsp_result", 32'(rsp_result), 32'(exp_q[0].res));
          check_eq("rsp_ovf", 32'(rsp_ovf), 32'(exp_q[0].ovf));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      mon_hold   = rsp_valid && !rsp_ready;
      mon_prev_v = rsp_valid;
      if (mon_rdy != '0) begin
        mon_e.id      = mon_g;
        mon_e.edge_no = cyc + 1;
        model_calc(req_a[mon_g*W +: W], req_b[mon_g*W +: W], req_sign[mon_g*2 +: 2],
                   mon_e.res, mon_e.ovf);
        exp_q.push_back(mon_e);
        grant_log.push_back(mon_g);
        m_last = mon_g;
      end
    end
  end

  task automatic wait_ready(input int lane, input string tag);
    int t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (!req_ready[lane] && t < 50);
    if (!req_ready[lane]) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    int t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (!rsp_valid && t < 50);
    if (!rsp_valid) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid) && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    check_eq(tag, exp_q.size(), 32'd0);
  endtask

  task automatic dir_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                        input logic [W-1:0] exp_res, input logic exp_ovf, input string tag);
    @(posedge clk); #1;
    req_a[W-1:0]  = a;
    req_b[W-1:0]  = b;
    req_sign[1:0] = s;
    req_valid     = 4'b0001;
    rsp_ready     = 1'b1;
    wait_ready(0, {tag, "_grant_timeout"});
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_id"}, 32'(rsp_id), 32'd0);
    check_eq({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
    check_eq({tag, "_ovf"}, 32'(rsp_ovf), 32'(exp_ovf));
    @(posedge clk); #1;
  endtask

  initial begin
    int           rr_exp [6];
    logic [N-1:0] acc;
    int           t;

    rr_exp    = '{0, 1, 2, 3, 0, 1};
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sign  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_req_ready", 32'(req_ready), 32'd0);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("reset_rsp_result", 32'(rsp_result), 32'd0);
    check_eq("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
    #2 rst = 1'b0;

    // All requesters continuously valid: order starts at 0 and rotates
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]    = rnd_opnd();
      req_b[i*W +: W]    = rnd_opnd();
      req_sign[i*2 +: 2] = 2'($urandom);
    end
    req_valid = '1;
    t = 0;
    while (grant_log.size() < 6 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    check_eq("rr_grant_count", 32'(grant_log.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      check_eq("rr_order", grant_log[k], rr_exp[k]);
    drain("rr_drain");

    dir_op(8'd5, 8'd3, 2'b00, 8'h08, 1'b0, "add_ab");
    dir_op(8'd5, 8'd3, 2'b01, 8'h02, 1'b0, "sub_b");
    dir_op(8'd5, 8'd3, 2'b10, 8'hFE, 1'b0, "sub_a");
    dir_op(8'd5, 8'd3, 2'b11, 8'hF8, 1'b0, "neg_sum");
`ifdef SATURATE_EN
    dir_op(8'h7F, 8'h01, 2'b00, 8'h7F, 1'b1, "ovf_pos");
    dir_op(8'h80, 8'h00, 2'b10, 8'h7F, 1'b1, "ovf_negmin");
`else
    dir_op(8'h7F, 8'h01, 2'b00, 8'h80, 1'b1, "ovf_pos");
    dir_op(8'h80, 8'h00, 2'b10, 8'h80, 1'b1, "ovf_negmin");
`endif

    // Consumer stall in RESP while other requesters wait
    @(posedge clk); #1;
    rsp_ready     = 1'b0;
    req_a[2*W +: W] = 8'h10;
    req_b[2*W +: W] = 8'h20;
    req_sign[5:4] = 2'b01;
    req_valid     = 4'b0100;
    wait_ready(2, "stall_grant_timeout");
    @(posedge clk); #1;
    req_valid = 4'b1011;
    wait_rsp("stall_rsp_timeout");
    for (int k = 0; k < 5; k++) begin
      check_eq("stall_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_ready", 32'(req_ready), 32'd0);
      check_eq("stall_result", 32'(rsp_result), 32'hF0);
      check_eq("stall_id", 32'(rsp_id), 32'd2);
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_eq("after_stall_grant", 32'(req_ready), 32'b1000);
    drain("stall_drain");

    // Asynchronous reset while an op is in EXEC
    @(posedge clk); #1;
    req_a[2*W +: W] = 8'h11;
    req_b[2*W +: W] = 8'h22;
    req_sign[5:4] = 2'b00;
    req_valid     = 4'b0100;
    wait_ready(2, "rst_grant_timeout");
    @(posedge clk); #2;
    req_valid = '1;
    rst       = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_result", 32'(rsp_result), 32'd0);
    check_eq("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
    @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk); #1;
    check_eq("rst_first_grant", 32'(req_ready), 32'b0001);

    // Randomized traffic; each requester holds its data until granted
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (acc[i] || (!req_valid[i] && $urandom_range(0, 2) == 0)) begin
          req_valid[i]       = acc[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          req_a[i*W +: W]    = rnd_opnd();
          req_b[i*W +: W]    = rnd_opnd();
          req_sign[i*2 +: 2] = 2'($urandom);
        end
      end
    end
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_share_ctrl.md
Name: addsub_share_ctrl

Overview:
Time-shares one signed add/sub datapath between N_REQ requesters over valid/ready handshakes. Arbitration is round-robin. The block captures the granted operands and sign controls, runs one datapath evaluation, and returns the result tagged with the requester ID and an overflow flag. It sits between the requesting engines and the single shared signed add/sub core.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits, two's complement (>=2)
ID_W, $clog2(N_REQ), requester ID width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester operation request
req_ready  out  N_REQ  per-requester accept, at most one bit high
req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B, same packing
req_sign  in  N_REQ*2  requester i at [i*2 +: 2]; bit1 negates A, bit0 negates B
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  ID_W  index of requester that issued the op
rsp_result  out  WIDTH  result
rsp_ovf  out  1  signed overflow of the true result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: all outputs 0, state IDLE, round-robin pointer last=N_REQ-1 (requester 0 wins first).
- Reset mid-operation: the in-flight op is discarded, no response is produced, and the requester must re-request.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching last+1, last+2, ... (mod N_REQ).
  - req_ready[g]=1 combinationally; all other ready bits are 0. No valid requests -> no ready, stay in IDLE.
  - At the edge where req_valid[g]&req_ready[g]: capture a, b, sign into operand regs, id<=g, last<=g, go to EXEC.
- EXEC:
  - One cycle. The datapath computes from the operand regs.
  - At the edge: result and ovf are registered, then go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_ovf are held stable until rsp_valid&rsp_ready.
  - At the handshake edge: rsp_valid<=0, go to IDLE.
  - No req_ready is asserted in EXEC or RESP.
- Latency and throughput:
  - Accept at edge k -> rsp_valid high after edge k+1.
  - Peak throughput is 1 op per 3 cycles (accept, EXEC, RESP with immediate rsp_ready).
- Arithmetic:
  - x = sign[1] ? -a : a, y = sign[0] ? -b : b, R = x + y, evaluated exactly in WIDTH+2 bits.
  - rsp_result = R mod 2^WIDTH.
  - rsp_ovf=1 iff R < -2^(WIDTH-1) or R > 2^(WIDTH-1)-1. This includes negating the minimum value, e.g. -(-128)+0 for WIDTH=8.
- Requests: a requester that drops req_valid before it is granted is never served. Request data must be stable while req_valid is high.
- Fairness: a continuously valid requester is served within N_REQ grants.

Optional Feature:
SATURATE_EN
- Defined: on overflow, rsp_result clamps to 2^(WIDTH-1)-1 if R>0, else to -2^(WIDTH-1). rsp_ovf is still reported.
- Undefined: rsp_result wraps modulo 2^WIDTH. rsp_ovf is unchanged.

Decomposition:
- Package addsub_share_pkg:
  - state enum (IDLE, EXEC, RESP);
  - sign-control encoding constants: ADD_AB=2'b00, SUB_B=2'b01, SUB_A=2'b10, NEG_SUM=2'b11;
  - function rr_pick(valid, last).
- One sub-module, signed_addsub_core:
  - purely combinational, parameterized WIDTH;
  - inputs a, b, sign; outputs result and ovf;
  - the saturation logic lives inside it, under SATURATE_EN.
- The controller holds the FSM, arbiter, operand regs and result regs.

Test Plan:
- req_valid[0], a=5, b=3, sign=00 -> one rsp after 2 edges: id=0, result=0x08, ovf=0.
- Same a/b with sign=01/10/11 -> results 0x02, 0xFE, 0xF8, ovf=0 each.
- a=0x7F, b=0x01, sign=00 -> 0x80, ovf=1 (SATURATE_EN: 0x7F). a=0x80, b=0x00, sign=10 -> 0x80, ovf=1 (SATURATE_EN: 0x7F).
- All four req_valid held high, rsp_ready=1 -> grant/rsp_id order 0,1,2,3,0,1; never two req_ready bits high.
- rsp_ready low for 5 cycles in RESP -> rsp fields stable, req_ready all 0; release -> handshake, next grant in IDLE.
- rst pulsed asynchronously during EXEC -> outputs 0 immediately, no response; after release requester 0 is granted first.
